// File: rtl/monitor_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : monitor_sched_pkg
//  Description : Shared types and default parameters for the monitor/strobe
//                trace-channel scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package monitor_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_HOLD  = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DW          = 8;
    localparam int DEF_THRESH      = 100;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage : monitor_sched_pkg
`default_nettype wire

// File: rtl/monitor_strobe_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_sched
//  Description : Combinational round-robin pick. Searches upward from ptr+1,
//                wrapping, and returns the first requester found.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_sched
    import monitor_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any_req
);

    logic r_found;
    int   r_cand;

    // First set request after the last winner, wrapping around the vector.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        r_found = 1'b0;
        r_cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            r_cand = (int'(ptr) + i) % NUM_REQ;
            if (!r_found && req[r_cand]) begin
                r_found       = 1'b1;
                grant[r_cand] = 1'b1;
                idx           = IW'(r_cand);
            end
        end
    end

endmodule : rr_arbiter_sched
`default_nettype wire

// File: rtl/monitor_strobe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : monitor_strobe_scheduler
//  Description : Shares one registered monitor/strobe trace channel between
//                NUM_REQ requesters with round-robin arbitration and a forced
//                idle gap after every issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module monitor_strobe_scheduler
    import monitor_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DW          = DEF_DW,
    parameter int THRESH      = DEF_THRESH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                       clk_sched,
    input  logic                       rst_n_sched,
    input  logic [NUM_REQ-1:0]         req_sched,
    input  logic [NUM_REQ*DW-1:0]      data_in_sched,
    output logic [NUM_REQ-1:0]         ack_sched,
    output logic [DW-1:0]              data_out_sched,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_sched,
    output logic                       mon_en_sched,
    output logic                       strobe_sched,
    output logic                       busy_sched,
    output logic [CNT_W-1:0]           issue_count_sched
);

    localparam int C_IW = $clog2(NUM_REQ);
    // Hold counter only ever holds HOLD_CYCLES-1 down to 0.
    localparam int C_HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_HW-1:0] C_HOLD_LOAD = (HOLD_CYCLES > 0) ? C_HW'(HOLD_CYCLES - 1) : '0;
    localparam logic [C_IW-1:0] C_PTR_RST   = C_IW'(NUM_REQ - 1);

    sched_state_t        r_state;
    logic [C_HW-1:0]     r_hold_cnt;
    logic [C_IW-1:0]     r_ptr;
    logic [NUM_REQ-1:0]  r_ack;

    logic [NUM_REQ-1:0]  w_grant;
    logic [C_IW-1:0]     w_idx;
    logic                w_any_req;
    logic                w_issue;

    rr_arbiter_sched #(
        .NUM_REQ (NUM_REQ),
        .IW      (C_IW)
    ) u_arb (
        .req     (req_sched),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .idx     (w_idx),
        .any_req (w_any_req)
    );

    // Sequencer: capture in IDLE, one ISSUE cycle, then the idle gap in HOLD.
    always_ff @(posedge clk_sched or negedge rst_n_sched) begin
        if (!rst_n_sched) begin
            r_state           <= SCHED_IDLE;
            r_hold_cnt        <= '0;
            r_ptr             <= C_PTR_RST;
            r_ack             <= '0;
            data_out_sched    <= '0;
            grant_idx_sched   <= '0;
            issue_count_sched <= '0;
        end else begin
            case (r_state)
                SCHED_IDLE: begin
                    if (w_any_req) begin
                        data_out_sched  <= data_in_sched[int'(w_idx)*DW +: DW];
                        grant_idx_sched <= w_idx;
                        r_ptr           <= w_idx;
                        r_ack           <= w_grant;
                        if (issue_count_sched != '1) begin
                            issue_count_sched <= issue_count_sched + CNT_W'(1);
                        end
                        r_state <= SCHED_ISSUE;
                    end
                end
                SCHED_ISSUE: begin
                    if (HOLD_CYCLES > 0) begin
                        r_hold_cnt <= C_HOLD_LOAD;
                        r_state    <= SCHED_HOLD;
                    end else begin
                        r_state <= SCHED_IDLE;
                    end
                end
                SCHED_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= SCHED_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - C_HW'(1);
                    end
                end
                default: r_state <= SCHED_IDLE;
            endcase
        end
    end

    // Pulses are decoded from state so an async reset clears them immediately.
    always_comb begin
        w_issue      = (r_state == SCHED_ISSUE);
        mon_en_sched = w_issue;
        ack_sched    = w_issue ? r_ack : '0;
        strobe_sched = w_issue && (32'(data_out_sched) > 32'(THRESH));
        busy_sched   = (r_state != SCHED_IDLE);
    end

`ifndef SYNTHESIS
    // Simulation trace of every issued byte.
    always @(posedge clk_sched) begin
        if (r_state == SCHED_ISSUE) begin
            $strobe("monitor_strobe_scheduler: grant=%0d data=%0d", grant_idx_sched, data_out_sched);
            if (strobe_sched) begin
                $strobeh(data_out_sched);
            end
        end
    end
`endif

endmodule : monitor_strobe_scheduler
`default_nettype wire

// File: tb/tb_monitor_strobe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_monitor_strobe_scheduler
//  Description : Self-checking bench. Three instances (default, CNT_W=2,
//                HOLD_CYCLES=0) share stimulus and are compared each cycle
//                against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_monitor_strobe_scheduler;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [31:0] din   = '0;

    logic [3:0]  ack0, ack1, ack2;
    logic [7:0]  do0, do1, do2;
    logic [1:0]  gi0, gi1, gi2;
    logic        me0, me1, me2, st0, st1, st2, bz0, bz1, bz2;
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    monitor_strobe_scheduler u_dut (
        .clk_sched(clk), .rst_n_sched(rst_n), .req_sched(req), .data_in_sched(din),
        .ack_sched(ack0), .data_out_sched(do0), .grant_idx_sched(gi0), .mon_en_sched(me0),
        .strobe_sched(st0), .busy_sched(bz0), .issue_count_sched(cnt0));

    monitor_strobe_scheduler #(.CNT_W(2)) u_sat (
        .clk_sched(clk), .rst_n_sched(rst_n), .req_sched(req), .data_in_sched(din),
        .ack_sched(ack1), .data_out_sched(do1), .grant_idx_sched(gi1), .mon_en_sched(me1),
        .strobe_sched(st1), .busy_sched(bz1), .issue_count_sched(cnt1));

    monitor_strobe_scheduler #(.HOLD_CYCLES(0)) u_h0 (
        .clk_sched(clk), .rst_n_sched(rst_n), .req_sched(req), .data_in_sched(din),
        .ack_sched(ack2), .data_out_sched(do2), .grant_idx_sched(gi2), .mon_en_sched(me2),
        .strobe_sched(st2), .busy_sched(bz2), .issue_count_sched(cnt2));

    // Reference model: per instance, the earliest cycle a request can be
    // sampled, the last winner, captured byte and saturating issue total.
    int HOLD_P [3] = '{2, 2, 0};
    int CMAX   [3] = '{65535, 3, 65535};
    int m_next [3];
    int m_ptr  [3];
    int m_cnt  [3];
    int m_dout [3];
    int m_gidx [3];
    bit m_iss  [3];
    int cyc;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            m_next[k] = 0; m_ptr[k] = 3; m_cnt[k] = 0;
            m_dout[k] = 0; m_gidx[k] = 0; m_iss[k] = 1'b0;
        end
    endtask

    task automatic check_inst(input int k);
        logic [31:0] a, d, g, m, s, b, c;
        case (k)
            0:       begin a = 32'(ack0); d = 32'(do0); g = 32'(gi0); m = 32'(me0); s = 32'(st0); b = 32'(bz0); c = 32'(cnt0); end
            1:       begin a = 32'(ack1); d = 32'(do1); g = 32'(gi1); m = 32'(me1); s = 32'(st1); b = 32'(bz1); c = 32'(cnt1); end
            default: begin a = 32'(ack2); d = 32'(do2); g = 32'(gi2); m = 32'(me2); s = 32'(st2); b = 32'(bz2); c = 32'(cnt2); end
        endcase
        check("mon_en",   k, m, 32'(m_iss[k]));
        check("ack",      k, a, m_iss[k] ? (32'd1 << m_gidx[k]) : 32'd0);
        check("strobe",   k, s, 32'(m_iss[k] && (m_dout[k] > 100)));
        check("busy",     k, b, 32'(cyc < m_next[k]));
        check("data_out", k, d, 32'(m_dout[k]));
        check("grant",    k, g, 32'(m_gidx[k]));
        check("count",    k, c, 32'(m_cnt[k]));
    endtask

    // One clock: model decides from presented inputs, then outputs are checked.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            m_iss[k] = 1'b0;
            if (cyc >= m_next[k] && req != 4'd0) begin
                for (int j = 1; j <= 4; j++) begin
                    int id;
                    id = (m_ptr[k] + j) % 4;
                    if (req[id] && !m_iss[k]) begin
                        m_iss[k]  = 1'b1;
                        m_ptr[k]  = id;
                        m_gidx[k] = id;
                        m_dout[k] = int'(din[id*8 +: 8]);
                    end
                end
                if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
                m_next[k] = cyc + 2 + HOLD_P[k];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) check_inst(k);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) check_inst(k);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        int n;
        @(negedge clk);
        do_reset();

        // Single request below threshold
        din = {$urandom} & 32'hFFFF_FF00 | 32'd50;
        req = 4'b0001;
        tick();
        check("t1_ack", 0, 32'(ack0), 32'd1);
        check("t1_mon", 0, 32'(me0), 32'd1);
        check("t1_data", 0, 32'(do0), 32'd50);
        check("t1_strobe", 0, 32'(st0), 32'd0);
        check("t1_count", 0, 32'(cnt0), 32'd1);
        req = 4'b0000;
        repeat (3) tick();

        // Threshold edges, period of four cycles
        din[7:0] = 8'd101;
        req = 4'b0001;
        tick();
        check("t2_strobe_101", 0, 32'(st0), 32'd1);
        din[7:0] = 8'd100;
        repeat (3) tick();
        tick();
        check("t2_mon_4later", 0, 32'(me0), 32'd1);
        check("t2_strobe_100", 0, 32'(st0), 32'd0);
        req = 4'b0000;
        repeat (4) tick();

        // Fairness with all requesters held
        do_reset();
        req = 4'b1111;
        n = 0;
        for (int t = 0; t < 100 && n < 8; t++) begin
            din = $urandom;
            tick();
            if (me0) begin
                check("t3_order", 0, 32'(gi0), 32'(n % 4));
                n++;
            end
        end
        check("t3_issues", 0, 32'(n), 32'd8);
        req = 4'b0000;
        repeat (5) tick();

        // Request only during HOLD is never serviced
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        repeat (2) tick();
        req = 4'b0000;
        repeat (3) begin
            tick();
            check("t4_no_ack2", 0, 32'(ack0[2]), 32'd0);
        end
        check("t4_idle", 0, 32'(bz0), 32'd0);

        // Async reset during ISSUE, then pointer restarts
        req = 4'b0001;
        tick();
        check("t5_in_issue", 0, 32'(me0), 32'd1);
        do_reset();
        check("t5_post_cnt", 0, 32'(cnt0), 32'd0);
        req = 4'b1000;
        tick();
        check("t5_grant3", 0, 32'(gi0), 32'd3);
        check("t5_ack3", 0, 32'(ack0), 32'b1000);
        req = 4'b0000;
        repeat (3) tick();

        // Saturation of a 2-bit counter
        do_reset();
        req = 4'b1111;
        n = 0;
        for (int t = 0; t < 100 && n < 5; t++) begin
            tick();
            if (me0) n++;
        end
        check("t6_issues", 0, 32'(n), 32'd5);
        check("t6_cnt16", 0, 32'(cnt0), 32'd5);
        check("t6_sat", 1, 32'(cnt1), 32'd3);

        // Zero hold: issue every other cycle
        n = 0;
        repeat (10) begin
            tick();
            if (me2) n++;
        end
        check("t7_h0_issues", 2, 32'(n), 32'd5);
        req = 4'b0000;
        repeat (4) tick();

        // Randomized soak
        for (int t = 0; t < 400; t++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            din = $urandom;
            if ($urandom_range(0, 150) == 0) do_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_monitor_strobe_scheduler
`default_nettype wire
